// File: rtl/if_pkg.sv
// Shared definitions for the multi-mode instruction-fetch stage: FSM state codes
// and the default NOP / HALT instruction words.
package if_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/memoria_programa.sv
// Single-port synchronous program RAM, read-first, registered read data.
// Writes beyond DEPTH are dropped; the read port is qualified by the caller.
module memoria_programa
    import if_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] dout_reg;
    logic             addr_ok;

    assign addr_ok = (32'(addr) < DEPTH);

    always_ff @(posedge clk) begin
        if (en) begin
            if (we && addr_ok) begin
                mem[addr] <= din;
            end
            dout_reg <= mem[addr];
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/etapa_if_multimodo.sv
// MIPS fetch stage with load/run/halt FSM, stall, branch flush and fetch counter.
// Optional IF_SINGLE_STEP_EN adds i_step: one fetch per rising edge of i_step.
module etapa_if_multimodo
    import if_pkg::*;
#(
    parameter int RAM_WIDTH_PROGRAMA = 32,
    parameter int CANT_BITS_ADDR     = 11,
    parameter int RAM_DEPTH_PROGRAMA = 2048,
    parameter     INIT_FILE_PROGRAMA = "",
    parameter logic [RAM_WIDTH_PROGRAMA-1:0] HALT_WORD = HALT_WORD_DEF[RAM_WIDTH_PROGRAMA-1:0],
    parameter logic [RAM_WIDTH_PROGRAMA-1:0] NOP_WORD  = NOP_WORD_DEF[RAM_WIDTH_PROGRAMA-1:0],
    parameter int COUNT_W            = 16
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_load_mode,
    input  logic                          i_wr_en,
    input  logic [CANT_BITS_ADDR-1:0]     i_wr_addr,
    input  logic [RAM_WIDTH_PROGRAMA-1:0] i_wr_data,
    input  logic                          i_start,
    input  logic                          i_enable,
    input  logic                          i_stall,
    input  logic                          i_branch_taken,
    input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
`ifdef IF_SINGLE_STEP_EN
    input  logic                          i_step,
`endif
    output logic [RAM_WIDTH_PROGRAMA-1:0] o_instruction,
    output logic                          o_valid,
    output logic [CANT_BITS_ADDR-1:0]     o_direccion_PC_PLUS_4,
    output logic [CANT_BITS_ADDR-1:0]     o_contador_programa,
    output logic                          o_halted,
    output logic [COUNT_W-1:0]            o_fetch_count
);

    logic [1:0]                    state_reg, state_next;
    logic [CANT_BITS_ADDR-1:0]     pc_reg, pc_next;
    logic [CANT_BITS_ADDR-1:0]     pc_plus_reg;
    logic                          valid_reg;
    logic                          show_ram_reg;
    logic [COUNT_W-1:0]            count_reg;
    logic [RAM_WIDTH_PROGRAMA-1:0] ram_q;

    logic in_run, in_load, branch, halt_seen, step_ok, fetch, ram_we, pc_in_range;

`ifdef IF_SINGLE_STEP_EN
    logic step_q_reg, step_fire_reg;

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            step_q_reg    <= 1'b0;
            step_fire_reg <= 1'b0;
        end else begin
            step_q_reg    <= i_step;
            step_fire_reg <= i_step & ~step_q_reg;
        end
    end

    assign step_ok = step_fire_reg;
`else
    assign step_ok = 1'b1;
`endif

    assign in_run      = (state_reg == ST_RUN);
    assign in_load     = (state_reg == ST_LOAD);
    assign branch      = in_run && i_branch_taken;
    assign halt_seen   = valid_reg && (o_instruction == HALT_WORD);
    assign fetch       = in_run && !branch && !halt_seen && i_enable && !i_stall && step_ok;
    assign ram_we      = in_load && i_wr_en;
    assign pc_in_range = (32'(pc_reg) < RAM_DEPTH_PROGRAMA);

    // The RAM port is shared: the write address owns it during LOAD, the PC otherwise.
    memoria_programa #(
        .WIDTH  (RAM_WIDTH_PROGRAMA),
        .ADDR_W (CANT_BITS_ADDR),
        .DEPTH  (RAM_DEPTH_PROGRAMA)
    ) u_memoria (
        .clk  (i_clock),
        .en   (fetch || ram_we),
        .we   (ram_we),
        .addr (in_load ? i_wr_addr : pc_reg),
        .din  (i_wr_data),
        .dout (ram_q)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_load_mode)  state_next = ST_LOAD;
                else if (i_start) state_next = ST_RUN;
            end
            ST_LOAD: begin
                pc_next = '0;
                if (!i_load_mode) state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (branch)         pc_next = i_branch_dir;
                else if (halt_seen) state_next = ST_HALT;
                else if (fetch)     pc_next = pc_reg + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= '0;
            pc_plus_reg  <= '0;
            valid_reg    <= 1'b0;
            show_ram_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (branch) begin
                valid_reg    <= 1'b0;
                show_ram_reg <= 1'b0;
            end else if (fetch) begin
                valid_reg    <= 1'b1;
                show_ram_reg <= pc_in_range;
                pc_plus_reg  <= pc_reg + 1'b1;
                if (count_reg != {COUNT_W{1'b1}}) count_reg <= count_reg + 1'b1;
            end
        end
    end

    // RAM data is not reset; the mask supplies NOP after reset, flush and out-of-range reads.
    assign o_instruction         = show_ram_reg ? ram_q : NOP_WORD;
    assign o_valid               = valid_reg;
    assign o_direccion_PC_PLUS_4 = pc_plus_reg;
    assign o_contador_programa   = pc_reg;
    assign o_halted              = (state_reg == ST_HALT);
    assign o_fetch_count         = count_reg;

endmodule

// File: tb/tb_etapa_if_multimodo.sv
// Directed bench for etapa_if_multimodo; expected fetched words are queued when
// the program is driven and popped as the stage presents them.
module tb_etapa_if_multimodo;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        i_clock = 1'b0;
    logic        i_soft_reset = 1'b0;
    logic        i_load_mode = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [10:0] i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic        i_start = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic [10:0] i_branch_dir = '0;
`ifdef IF_SINGLE_STEP_EN
    logic        i_step = 1'b0;
`endif
    logic [31:0] o_instruction;
    logic        o_valid;
    logic [10:0] o_direccion_PC_PLUS_4;
    logic [10:0] o_contador_programa;
    logic        o_halted;
    logic [15:0] o_fetch_count;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 i_clock = ~i_clock;

    etapa_if_multimodo dut (
        .i_clock               (i_clock),
        .i_soft_reset          (i_soft_reset),
        .i_load_mode           (i_load_mode),
        .i_wr_en               (i_wr_en),
        .i_wr_addr             (i_wr_addr),
        .i_wr_data             (i_wr_data),
        .i_start               (i_start),
        .i_enable              (i_enable),
        .i_stall               (i_stall),
        .i_branch_taken        (i_branch_taken),
        .i_branch_dir          (i_branch_dir),
`ifdef IF_SINGLE_STEP_EN
        .i_step                (i_step),
`endif
        .o_instruction         (o_instruction),
        .o_valid               (o_valid),
        .o_direccion_PC_PLUS_4 (o_direccion_PC_PLUS_4),
        .o_contador_programa   (o_contador_programa),
        .o_halted              (o_halted),
        .o_fetch_count         (o_fetch_count)
    );

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fetch(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, o_instruction);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 64'(o_instruction), 64'(e));
            chk({tag, "_valid"}, 64'(o_valid), 64'd1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_instr"}, 64'(o_instruction), 64'(NOP));
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_pc"}, 64'(o_contador_programa), 64'd0);
        chk({tag, "_pc4"}, 64'(o_direccion_PC_PLUS_4), 64'd0);
        chk({tag, "_halted"}, 64'(o_halted), 64'd0);
        chk({tag, "_count"}, 64'(o_fetch_count), 64'd0);
    endtask

    task automatic async_reset(input string tag);
        i_soft_reset = 1'b0;
        #1;
        check_reset_state(tag);
        @(negedge i_clock);
        i_soft_reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic write_word(input logic [10:0] a, input logic [31:0] d);
        i_wr_en = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic start_run(input string tag);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk({tag, "_start_pc"}, 64'(o_contador_programa), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check_reset_state("reset");
        @(negedge i_clock);
        i_soft_reset = 1'b1;
        i_enable = 1'b1;

        // Program load, then a write attempt in IDLE that must be ignored.
        i_load_mode = 1'b1;
        tick();
        write_word(11'd0, 32'h0000_0005);
        write_word(11'd1, 32'h0000_0002);
        write_word(11'd2, HALT);
        write_word(11'd10, HALT);
        i_load_mode = 1'b0;
        tick();
        write_word(11'd0, 32'h0000_00AA);

`ifdef IF_SINGLE_STEP_EN
        start_run("step");
        repeat (3) tick();
        chk("step_idle_count", 64'(o_fetch_count), 64'd0);
        chk("step_idle_valid", 64'(o_valid), 64'd0);
        exp_q.push_back(32'h5);
        exp_q.push_back(32'h2);
        i_step = 1'b1; tick();
        i_step = 1'b0; tick();
        check_fetch("step1");
        chk("step1_count", 64'(o_fetch_count), 64'd1);
        repeat (2) tick();
        chk("step1_hold_count", 64'(o_fetch_count), 64'd1);
        i_step = 1'b1; tick(); tick(); tick();
        i_step = 1'b0; tick();
        check_fetch("step2");
        chk("step2_count", 64'(o_fetch_count), 64'd2);
        chk("step2_pc", 64'(o_contador_programa), 64'd2);
`else
        // Straight run to HALT.
        start_run("run");
        exp_q.push_back(32'h5);
        exp_q.push_back(32'h2);
        exp_q.push_back(HALT);
        tick(); check_fetch("run_w0");
        chk("run_pc1", 64'(o_contador_programa), 64'd1);
        chk("run_pc4_1", 64'(o_direccion_PC_PLUS_4), 64'd1);
        chk("run_cnt1", 64'(o_fetch_count), 64'd1);
        tick(); check_fetch("run_w1");
        tick(); check_fetch("run_w2");
        chk("run_pc3", 64'(o_contador_programa), 64'd3);
        chk("run_cnt3", 64'(o_fetch_count), 64'd3);
        chk("run_not_halted_yet", 64'(o_halted), 64'd0);
        tick();
        chk("run_halted", 64'(o_halted), 64'd1);
        chk("run_halt_pc", 64'(o_contador_programa), 64'd3);
        tick();
        chk("halt_frozen_pc", 64'(o_contador_programa), 64'd3);
        chk("halt_frozen_cnt", 64'(o_fetch_count), 64'd3);

        // Reset mid-RUN, restart, enable-low hold, stall hold.
        async_reset("rst_halt");
        start_run("rs");
        exp_q.push_back(32'h5);
        tick(); check_fetch("rs_w0");
        async_reset("rst_midrun");
        start_run("rs2");
        exp_q.push_back(32'h5);
        exp_q.push_back(32'h2);
        exp_q.push_back(HALT);
        tick(); check_fetch("rs2_w0");
        i_enable = 1'b0;
        repeat (2) tick();
        chk("en0_pc", 64'(o_contador_programa), 64'd1);
        chk("en0_cnt", 64'(o_fetch_count), 64'd1);
        i_enable = 1'b1;
        tick(); check_fetch("rs2_w1");
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_instr", 64'(o_instruction), 64'h2);
            chk("stall_pc", 64'(o_contador_programa), 64'd2);
            chk("stall_cnt", 64'(o_fetch_count), 64'd2);
        end
        i_stall = 1'b0;
        tick(); check_fetch("stall_resume_halt");
        tick();
        chk("stall_halted", 64'(o_halted), 64'd1);

        // Branch flush to address 10 holding HALT.
        async_reset("rst_br");
        start_run("br");
        exp_q.push_back(32'h5);
        tick(); check_fetch("br_w0");
        i_branch_taken = 1'b1;
        i_branch_dir = 11'd10;
        tick();
        i_branch_taken = 1'b0;
        chk("br_flush_instr", 64'(o_instruction), 64'(NOP));
        chk("br_flush_valid", 64'(o_valid), 64'd0);
        chk("br_flush_pc", 64'(o_contador_programa), 64'd10);
        chk("br_flush_cnt", 64'(o_fetch_count), 64'd1);
        exp_q.push_back(HALT);
        tick(); check_fetch("br_halt");
        chk("br_halt_pc", 64'(o_contador_programa), 64'd11);
        tick();
        chk("br_halted", 64'(o_halted), 64'd1);
        chk("br_halted_pc", 64'(o_contador_programa), 64'd11);

        // Branch squashes a pending HALT.
        async_reset("rst_sq");
        start_run("sq");
        exp_q.push_back(32'h5);
        exp_q.push_back(32'h2);
        exp_q.push_back(HALT);
        repeat (3) begin
            tick(); check_fetch("sq_w");
        end
        i_branch_taken = 1'b1;
        i_branch_dir = 11'd0;
        tick();
        i_branch_taken = 1'b0;
        chk("sq_not_halted", 64'(o_halted), 64'd0);
        chk("sq_pc", 64'(o_contador_programa), 64'd0);
        chk("sq_valid", 64'(o_valid), 64'd0);
        exp_q.push_back(32'h5);
        tick(); check_fetch("sq_refetch");
        chk("sq_cnt", 64'(o_fetch_count), 64'd4);
`endif
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
